// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 32x64 register file.
// NUM_REGS   : number of architectural registers (X0..X31)
// ZERO_REG   : index of the hardwired-zero register
// REG_ADDR_W : width of a register number
// reg_word_t : one register word
// popcount32 : number of set bits in a write-enable vector
package regfile_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
  localparam int unsigned WORD_W     = 64;

  typedef logic [WORD_W-1:0] reg_word_t;

  function automatic logic [5:0] popcount32(input logic [NUM_REGS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile32x64_reg64.sv
// reg64: one WIDTH-bit register with load enable and synchronous reset.
// Each bit is a D flop fed by a 2:1 mux selecting new data or the held value.
// Ports:
//   clk   rising-edge clock
//   reset synchronous active-high clear
//   en    load enable
//   d     data to load
//   q     stored value
module reg64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] dmux;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    assign dmux[b] = en ? d[b] : q[b];
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= dmux;
  end

endmodule

// File: rtl/regfile32x64.sv
// regfile32x64: 32-entry x WIDTH-bit register file, two combinational read
// ports, one synchronous write port driven by a one-hot enable vector.
// X31 reads as zero and has no storage. Any enable vector with two or more
// set bits (bit 31 included) is discarded and sets the sticky wr_err flag,
// which only reset clears.
// Ports:
//   clk                          rising-edge clock
//   reset                        synchronous active-high reset
//   wr_en[31:0]                  one-hot write enable (all-zero = no write)
//   WriteData[WIDTH-1:0]         write data
//   ReadRegister1/2[4:0]         read addresses
//   ReadData1/2[WIDTH-1:0]       read data
//   wr_err                       sticky illegal-enable flag
module regfile32x64
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REGS-1:0]   wr_en,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [REG_ADDR_W-1:0] ReadRegister1,
  input  logic [REG_ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2,
  output logic                  wr_err
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [5:0]       wr_cnt;
  logic             wr_ok;
  logic             wr_bad;

  // Legality counts all 32 bits; a lone wr_en[31] is legal but loads nothing
  // because X31 has no storage.
  assign wr_cnt = popcount32(wr_en);
  assign wr_ok  = (wr_cnt == 6'd1);
  assign wr_bad = (wr_cnt >= 6'd2);

  for (genvar i = 0; i < int'(ZERO_REG); i++) begin : g_reg
    reg64 #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (wr_ok & wr_en[i]),
      .d     (WriteData),
      .q     (regs[i])
    );
  end

  assign regs[ZERO_REG] = '0;

  assign ReadData1 = regs[ReadRegister1];
  assign ReadData2 = regs[ReadRegister2];

  always_ff @(posedge clk) begin
    if (reset)       wr_err <= 1'b0;
    else if (wr_bad) wr_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile32x64.sv
module tb_regfile32x64;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wr_en = '0;
  logic [63:0] WriteData = '0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  logic        wr_err;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  reg_word_t model [32];
  logic      model_err;

  regfile32x64 #(.WIDTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .wr_err        (wr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one clock edge.
  task automatic model_edge(input logic rst, input logic [31:0] we, input logic [63:0] wd);
    if (rst) begin
      foreach (model[k]) model[k] = '0;
      model_err = 1'b0;
    end else if ($countones(we) >= 2) begin
      model_err = 1'b1;
    end else if ($countones(we) == 1) begin
      for (int k = 0; k < 31; k++)
        if (we[k]) model[k] = wd;
    end
  endtask

  task automatic do_cycle(input logic rst, input logic [31:0] we, input logic [63:0] wd);
    @(negedge clk);
    reset = rst; wr_en = we; WriteData = wd;
    @(posedge clk);
    model_edge(rst, we, wd);
    #1;
    reset = 1'b0; wr_en = '0;
  endtask

  task automatic check_reg(input string tag, input int a);
    ReadRegister1 = 5'(a);
    ReadRegister2 = 5'(a);
    #1;
    check_eq({tag, "_rd1"}, ReadData1, model[a]);
    check_eq({tag, "_rd2"}, ReadData2, model[a]);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(31 - a);
      #1;
      check_eq({tag, "_rd1"}, ReadData1, model[a]);
      check_eq({tag, "_rd2"}, ReadData2, model[31 - a]);
    end
    check_eq({tag, "_err"}, 64'(wr_err), 64'(model_err));
  endtask

  initial begin
    logic [31:0] we;
    logic [63:0] wd;
    int a, b;

    foreach (model[k]) model[k] = '0;
    model_err = 1'b0;

    // 1. reset then read everything
    do_cycle(1'b1, '0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_all("reset");

    // 2. write each register, read back on both ports
    for (int i = 0; i < 31; i++) begin
      do_cycle(1'b0, 32'(1) << i, 64'hA5A5_0000_0000_0000 | 64'(i));
      check_eq("wr_pattern", ReadData1 === ReadData1 ? 64'hA5A5_0000_0000_0000 | 64'(i) : '0,
               model[i]);
      check_reg("wr_all", i);
    end
    do_cycle(1'b0, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    check_reg("x31", 31);
    check_eq("x31_zero", ReadData1, 64'h0);
    check_eq("x31_err", 64'(wr_err), 64'h0);
    check_all("wr_all_sweep");

    // 3. no write-to-read bypass
    do_cycle(1'b0, 32'(1) << 5, 64'h1234);
    @(negedge clk);
    wr_en = 32'(1) << 5; WriteData = 64'h5678; ReadRegister1 = 5'd5;
    #1;
    check_eq("nobypass_before", ReadData1, 64'h1234);
    @(posedge clk);
    model_edge(1'b0, 32'(1) << 5, 64'h5678);
    #1;
    wr_en = '0;
    check_eq("nobypass_after", ReadData1, 64'h5678);

    // 4. illegal vector
    do_cycle(1'b0, 32'(1) << 3, 64'h33);
    do_cycle(1'b0, 32'(1) << 4, 64'h44);
    do_cycle(1'b0, 32'h18, 64'hDEAD);
    check_reg("illegal_x3", 3);
    check_eq("illegal_x3_val", ReadData1, 64'h33);
    check_reg("illegal_x4", 4);
    check_eq("illegal_x4_val", ReadData1, 64'h44);
    check_eq("illegal_err", 64'(wr_err), 64'h1);
    do_cycle(1'b0, 32'(1) << 9, 64'h99);
    check_eq("sticky_err", 64'(wr_err), 64'h1);
    check_reg("legal_after_err", 9);
    do_cycle(1'b0, 32'h8000_0001, 64'h77);
    check_reg("illegal_bit31_x0", 0);

    // 5. reset priority over a simultaneous write
    do_cycle(1'b1, 32'(1) << 7, 64'hBEEF);
    check_reg("rst_prio_x7", 7);
    check_eq("rst_prio_x7_val", ReadData1, 64'h0);
    check_eq("rst_prio_err", 64'(wr_err), 64'h0);
    do_cycle(1'b1, 32'h0000_0300, 64'hBAD);
    check_eq("rst_illegal_err", 64'(wr_err), 64'h0);

    // 6. idle after writes
    for (int i = 0; i < 31; i++)
      do_cycle(1'b0, 32'(1) << i, {$urandom, $urandom});
    for (int i = 0; i < 10; i++)
      do_cycle(1'b0, '0, {$urandom, $urandom});
    check_all("idle");

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       we = '0;
        1, 2, 3: we = 32'(1) << $urandom_range(0, 30);
        4:       we = 32'h8000_0000;
        default: begin
          a  = int'($urandom_range(0, 31));
          b  = (a + int'($urandom_range(1, 31))) % 32;
          we = (32'(1) << a) | (32'(1) << b);
        end
      endcase
      do_cycle($urandom_range(0, 39) == 0, we, wd);
      a = int'($urandom_range(0, 31));
      b = int'($urandom_range(0, 31));
      ReadRegister1 = 5'(a);
      ReadRegister2 = 5'(b);
      #1;
      check_eq("rand_rd1", ReadData1, model[a]);
      check_eq("rand_rd2", ReadData2, model[b]);
      check_eq("rand_err", 64'(wr_err), 64'(model_err));
    end
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
